// File: rtl/alu_seq_core.sv
// Sequential ALU: single-cycle arithmetic, logic, shift and rotate ops, plus
// iterative shift-add multiply and restoring divide (one bit per cycle).
module alu_seq_core #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 start,
    output logic [2*WIDTH-1:0]   result,
    output logic [3:0]           flags,
    output logic                 err,
    output logic                 busy,
    output logic                 done
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_ROL = 4'd8;
    localparam logic [3:0] OP_ROR = 4'd9;
    localparam logic [3:0] OP_MUL = 4'd10;
    localparam logic [3:0] OP_DIV = 4'd11;
    localparam logic [3:0] OP_CMP = 4'd12;

    typedef enum logic [1:0] {IDLE, EXEC, ITER, DONE} state_t;

    state_t             state;
    logic [3:0]         op_mode;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [WIDTH-1:0]   work_hi;
    logic [WIDTH-1:0]   work_lo;
    logic [CW-1:0]      iter_cnt;

    logic [2:0]         sh_amt;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     sub_diff;
    logic [WIDTH:0]     shl_t;
    logic [WIDTH:0]     shr_t;
    logic [WIDTH-1:0]   rol_res;
    logic [WIDTH-1:0]   ror_res;

    logic [2*WIDTH-1:0] alu_res;
    logic               alu_c;
    logic               alu_v;
    logic               alu_err;
    logic               alu_inv;
    logic               alu_keep;
    logic               alu_n;
    logic               alu_z;
    logic               is_iter_op;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [WIDTH-1:0]   step_hi;
    logic [WIDTH-1:0]   step_lo;
    logic               last_iter;

    assign sh_amt   = op_b[2:0];
    assign add_sum  = {1'b0, op_a} + {1'b0, op_b};
    assign sub_diff = {1'b0, op_a} - {1'b0, op_b};
    // Extra bit on each side captures the last bit shifted out as carry.
    assign shl_t    = {1'b0, op_a} << sh_amt;
    assign shr_t    = {op_a, 1'b0} >> sh_amt;
    assign rol_res  = (op_a << sh_amt) | (op_a >> (WIDTH - sh_amt));
    assign ror_res  = (op_a >> sh_amt) | (op_a << (WIDTH - sh_amt));

    assign is_iter_op = (op_mode == OP_MUL) || ((op_mode == OP_DIV) && (op_b != '0));

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        alu_res  = '0;
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        alu_err  = 1'b0;
        alu_inv  = 1'b0;
        alu_keep = 1'b0;
        case (op_mode)
            OP_ADD: begin
                alu_res = {{(WIDTH-1){1'b0}}, add_sum};
                alu_c   = add_sum[WIDTH];
                alu_v   = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (add_sum[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_SUB, OP_CMP: begin
                alu_res  = {{WIDTH{1'b0}}, sub_diff[WIDTH-1:0]};
                alu_c    = sub_diff[WIDTH];
                alu_v    = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (sub_diff[WIDTH-1] != op_a[WIDTH-1]);
                alu_keep = (op_mode == OP_CMP);
            end
            OP_AND: alu_res = {{WIDTH{1'b0}}, op_a & op_b};
            OP_OR:  alu_res = {{WIDTH{1'b0}}, op_a | op_b};
            OP_XOR: alu_res = {{WIDTH{1'b0}}, op_a ^ op_b};
            OP_NOT: alu_res = {{WIDTH{1'b0}}, ~op_a};
            OP_SHL: begin
                alu_res = {{WIDTH{1'b0}}, shl_t[WIDTH-1:0]};
                alu_c   = shl_t[WIDTH];
            end
            OP_SHR: begin
                alu_res = {{WIDTH{1'b0}}, shr_t[WIDTH:1]};
                alu_c   = shr_t[0];
            end
            OP_ROL: begin
                alu_res = {{WIDTH{1'b0}}, rol_res};
                alu_c   = (sh_amt != 3'd0) && rol_res[0];
            end
            OP_ROR: begin
                alu_res = {{WIDTH{1'b0}}, ror_res};
                alu_c   = (sh_amt != 3'd0) && ror_res[WIDTH-1];
            end
            OP_MUL: ;
            OP_DIV: begin
                // Only reached on divide-by-zero; nonzero divisors go through ITER.
                alu_res = '1;
                alu_err = 1'b1;
            end
            default: begin
                alu_err = 1'b1;
                alu_inv = 1'b1;
            end
        endcase
    end

    assign alu_n = alu_res[WIDTH-1];
    assign alu_z = (alu_res[WIDTH-1:0] == '0);

    // One iteration step: shift-add for MUL, restoring subtract for DIV.
    assign mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, op_a} : '0);
    assign div_shift = {work_hi, work_lo[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, op_b};

    always_comb begin
        if (op_mode == OP_MUL) begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], work_lo[WIDTH-1:1]};
        end else begin
            step_hi = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
            step_lo = {work_lo[WIDTH-2:0], ~div_diff[WIDTH]};
        end
    end

    assign last_iter = (iter_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        // NOTE: operand and work registers are deliberately not reset; they are reloaded before every use.
        if (state == IDLE && start) begin
            op_mode <= mode;
            op_a    <= a;
            op_b    <= b;
        end
        if (state == EXEC) begin
            work_hi  <= '0;
            work_lo  <= (op_mode == OP_DIV) ? op_a : op_b;
            iter_cnt <= '0;
        end else if (state == ITER) begin
            work_hi  <= step_hi;
            work_lo  <= step_lo;
            iter_cnt <= iter_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            result <= '0;
            flags  <= '0;
            err    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: if (start) state <= EXEC;
                EXEC: begin
                    busy <= 1'b1;
                    if (is_iter_op) begin
                        state <= ITER;
                    end else begin
                        state <= DONE;
                        done  <= 1'b1;
                        err   <= alu_err;
                        flags <= alu_inv ? 4'b0000 : {alu_n, alu_v, alu_c, alu_z};
                        if (!alu_keep) result <= alu_res;
                    end
                end
                ITER: if (last_iter) begin
                    state  <= DONE;
                    done   <= 1'b1;
                    err    <= 1'b0;
                    result <= {step_hi, step_lo};
                    if (op_mode == OP_MUL)
                        flags <= {step_hi[WIDTH-1], 2'b00, ({step_hi, step_lo} == '0)};
                    else
                        flags <= {step_lo[WIDTH-1], 2'b00, (step_lo == '0)};
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_core.sv
// Directed-vector bench for alu_seq_core (WIDTH=8): results, flags, latency,
// busy window, start-ignore, invalid mode and mid-operation reset.
module tb_alu_seq_core;

    localparam int WIDTH = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [3:0]        mode;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic [2*WIDTH-1:0] result;
    logic [3:0]        flags;
    logic              err;
    logic              busy;
    logic              done;

    int checks   = 0;
    int failures = 0;

    alu_seq_core #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .mode   (mode),
        .a      (a),
        .b      (b),
        .start  (start),
        .result (result),
        .flags  (flags),
        .err    (err),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Issue one operation, scramble inputs after acceptance, then wait for done.
    // Latency is reported as the edge (counted from the accepting edge) that samples done high.
    task automatic run_op(input string tag, input logic [3:0] m, input logic [7:0] opa,
                          input logic [7:0] opb, input logic [15:0] exp_res, input logic [3:0] exp_flags,
                          input logic exp_err, input int exp_lat, input int exp_busy, input bit poke);
        int n      = 0;
        int busy_n = 0;
        bit seen   = 1'b0;
        bit extra  = 1'b0;
        @(negedge clk);
        mode  = m;
        a     = opa;
        b     = opb;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        mode  = 4'($urandom);
        a     = 8'($urandom);
        b     = 8'($urandom);
        while (!seen && n < 40) begin
            if (poke) start = n[0];
            @(posedge clk);
            #1;
            n++;
            if (busy) busy_n++;
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        check({tag, "/done_seen"}, 32'(seen), 32'd1);
        check({tag, "/latency"}, 32'(n + 1), 32'(exp_lat));
        check({tag, "/busy_cycles"}, 32'(busy_n), 32'(exp_busy));
        check({tag, "/result"}, 32'(result), 32'(exp_res));
        check({tag, "/flags"}, 32'(flags), 32'(exp_flags));
        check({tag, "/err"}, 32'(err), 32'(exp_err));
        @(posedge clk);
        #1;
        check({tag, "/done_pulse"}, 32'(done), 32'd0);
        check({tag, "/busy_clear"}, 32'(busy), 32'd0);
        if (poke) begin
            repeat (3) begin
                @(posedge clk);
                #1;
                if (done) extra = 1'b1;
            end
            check({tag, "/no_queued_start"}, 32'(extra), 32'd0);
        end
    endtask

    initial begin
        bit abort_done = 1'b0;

        // Reset held with start asserted: reset must win.
        rst   = 1'b1;
        start = 1'b1;
        mode  = 4'd0;
        a     = 8'hFF;
        b     = 8'h01;
        repeat (3) @(posedge clk);
        #1;
        check("rst/result", 32'(result), 32'h0);
        check("rst/flags", 32'(flags), 32'h0);
        check("rst/err", 32'(err), 32'h0);
        check("rst/busy", 32'(busy), 32'h0);
        check("rst/done", 32'(done), 32'h0);
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;

        // flags = {N,V,C,Z}
        run_op("add_ff_01", 4'd0,  8'hFF, 8'h01, 16'h0100, 4'b0011, 1'b0, 2, 1, 1'b0);
        run_op("sub_80_01", 4'd1,  8'h80, 8'h01, 16'h007F, 4'b0100, 1'b0, 2, 1, 1'b0);
        run_op("cmp_05_07", 4'd12, 8'h05, 8'h07, 16'h007F, 4'b1010, 1'b0, 2, 1, 1'b0);
        run_op("mul_ff_ff", 4'd10, 8'hFF, 8'hFF, 16'hFE01, 4'b1000, 1'b0, 10, 9, 1'b1);
        run_op("div_64_07", 4'd11, 8'h64, 8'h07, 16'h020E, 4'b0000, 1'b0, 10, 9, 1'b0);
        run_op("div_by_0",  4'd11, 8'h55, 8'h00, 16'hFFFF, 4'b1000, 1'b1, 2, 1, 1'b0);
        run_op("invalid14", 4'd14, 8'h12, 8'h34, 16'h0000, 4'b0000, 1'b1, 2, 1, 1'b0);
        run_op("add_01_01", 4'd0,  8'h01, 8'h01, 16'h0002, 4'b0000, 1'b0, 2, 1, 1'b0);
        run_op("add_ovf",   4'd0,  8'h7F, 8'h01, 16'h0080, 4'b1100, 1'b0, 2, 1, 1'b0);
        run_op("and",       4'd2,  8'hF0, 8'h0F, 16'h0000, 4'b0001, 1'b0, 2, 1, 1'b0);
        run_op("or",        4'd3,  8'h12, 8'h21, 16'h0033, 4'b0000, 1'b0, 2, 1, 1'b0);
        run_op("xor",       4'd4,  8'hF0, 8'h0F, 16'h00FF, 4'b1000, 1'b0, 2, 1, 1'b0);
        run_op("not",       4'd5,  8'hFF, 8'h00, 16'h0000, 4'b0001, 1'b0, 2, 1, 1'b0);
        run_op("shl_1",     4'd6,  8'h81, 8'h01, 16'h0002, 4'b0010, 1'b0, 2, 1, 1'b0);
        run_op("shl_0",     4'd6,  8'hA5, 8'h00, 16'h00A5, 4'b1000, 1'b0, 2, 1, 1'b0);
        run_op("shr_9",     4'd7,  8'h81, 8'h09, 16'h0040, 4'b0010, 1'b0, 2, 1, 1'b0);
        run_op("rol_1",     4'd8,  8'h81, 8'h01, 16'h0003, 4'b0010, 1'b0, 2, 1, 1'b0);
        run_op("ror_1",     4'd9,  8'h81, 8'h01, 16'h00C0, 4'b1010, 1'b0, 2, 1, 1'b0);
        run_op("mul_0d_0b", 4'd10, 8'h0D, 8'h0B, 16'h008F, 4'b0000, 1'b0, 10, 9, 1'b0);
        run_op("mul_zero",  4'd10, 8'h00, 8'h05, 16'h0000, 4'b0001, 1'b0, 10, 9, 1'b0);
        run_op("div_05_07", 4'd11, 8'h05, 8'h07, 16'h0500, 4'b0001, 1'b0, 10, 9, 1'b0);

        // Reset during the 4th ITER cycle of a MUL aborts it.
        @(negedge clk);
        mode  = 4'd10;
        a     = 8'hFF;
        b     = 8'hFF;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (done) abort_done = 1'b1;
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort/result", 32'(result), 32'h0);
        check("abort/flags", 32'(flags), 32'h0);
        check("abort/err", 32'(err), 32'h0);
        check("abort/busy", 32'(busy), 32'h0);
        check("abort/done", 32'(done), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done) abort_done = 1'b1;
        end
        check("abort/no_done", 32'(abort_done), 32'd0);
        run_op("after_abort", 4'd0, 8'h01, 8'h02, 16'h0003, 4'b0000, 1'b0, 2, 1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
